multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath. Replaces the single-cycle opcode decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects and write enables.
- Stalls on a shared memory port through a ready handshake.
- Flags unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
op_code  input  6  IR[31:26]
funct  input  6  IR[5:0], used only when op_code=000000
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero=1
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mdr_write  output  1  MDR load
reg_write  output  1  register file write
reg_dst  output  2  00=rt, 01=rd, 10=$31
mem_to_reg  output  2  00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct, 11=and
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A
illegal  output  1  sticky unsupported-opcode flag
state  output  4  current state, for debug
instr_count  output  CNT_W  retired instructions

Behaviour:
- State register updates on posedge clk. Outputs decode from state only, except the memory-completion qualifiers listed below.
- Any output not listed for a state is 0.
- rst=1 at a clock edge: state<=FETCH, illegal<=0, instr_count<=0.
- While rst=1, every write enable and memory request is forced to 0, regardless of state.
- Reset mid-instruction abandons it. No partial writes occur after the reset edge.
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11
  - JR=12, JAL=13, TRAP=15
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target into ALUOut).
  - Next state by op_code:
    - 100011 or 101011 -> MEM_ADDR
    - 000000 with funct=001000 -> JR; any other funct -> R_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 or 001100 -> I_EXEC
    - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD if op_code=100011, else MEM_WR.
- MEM_RD:
  - mem_read=1, iord=1, mdr_write=mem_ready.
  - Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Go to FETCH; instruction retires.
- MEM_WR:
  - mem_write=1, iord=1.
  - Hold until mem_ready=1, then go to FETCH; instruction retires.
  - mem_write must stay high and stable while stalled.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Go to FETCH; instruction retires.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1.
  - Go to FETCH; instruction retires regardless of zero.
- JUMP: pc_source=10, pc_write=1. Go to FETCH; instruction retires.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for 001000, 11 for 001100. Go to I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Go to FETCH; instruction retires.
- JR: pc_source=11, pc_write=1. Go to FETCH; instruction retires.
- TRAP:
  - illegal<=1 on entry. Terminal: stays in TRAP until rst.
  - No retire; all enables 0.
- instr_count:
  - Increments by 1 on each retire edge.
  - Wraps from all-ones to 0.
- Cycle counts, assuming mem_ready=1 throughout:
  - lw=5; sw, R-type, addi, andi=4; beq, j, jr=3.
  - Each stalled memory cycle adds 1.

Optional Feature:
- Macro CTRL_JAL_EN.
- Defined:
  - DECODE with op_code=000011 goes to JAL.
  - JAL drives reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4), pc_source=10, pc_write=1, then goes to FETCH; instruction retires.
  - Total jal latency is 3 cycles.
- Undefined: op_code=000011 goes to TRAP, and state code 13 is unreachable.

Test Plan:
- Reset: hold rst=1 for 2 cycles with mem_ready=1 -> state=0, all enables 0, illegal=0, instr_count=0. First post-reset cycle shows mem_read=1, ir_write=1, pc_write=1.
- lw with mem_ready=1 -> state sequence 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=01 and reg_dst=00. instr_count goes 0->1.
- sw with mem_ready low for 3 cycles in MEM_WR -> state stays 5 for 4 cycles with mem_write=1 and iord=1 each cycle. Returns to 0; no reg_write at any point.
- beq with zero=1, then zero=0 -> state 8 each time with pc_write_cond=1, alu_op=01, pc_source=01. instr_count advances by 2.
- R-type with funct=100000, then funct=001000 -> first takes states 6,7 (reg_dst=01). Second takes state 12 with pc_source=11 and pc_write=1.
- op_code=111111 -> state 15, illegal=1, held for 10 cycles, count unchanged. With CTRL_JAL_EN, op_code=000011 -> state 13 with reg_dst=10, mem_to_reg=10, reg_write=1.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control                                           |
// | Description : Moore sequencer for the multi-cycle MIPS datapath. It steps   |
// |               each instruction through fetch/decode/execute/memory/        |
// |               writeback, drives every datapath select and write enable,    |
// |               stalls on the shared memory port using mem_ready, and        |
// |               raises a sticky flag on unsupported opcodes.                 |
// | Option      : define CTRL_JAL_EN to add the jal (op_code 000011) path.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12,
`ifdef CTRL_JAL_EN
    S_JAL      = 4'd13,
`endif
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;

  // The zero flag is consumed by the datapath through pc_write_cond; the
  // sequencer itself never branches on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // State register, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal <= 1'b1;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state and output decode; reset masks every enable and request.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes.
        alu_src_b = 2'b11;
        case (op_code)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
`ifdef CTRL_JAL_EN
          OP_JAL:           state_d = S_JAL;
`endif
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        // Request stays asserted unchanged for the whole stall.
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_code == OP_ANDI) ? 2'b11 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JR: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
`ifdef CTRL_JAL_EN
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
`endif
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
    end
  end

endmodule
`default_nettype wire
